// File: rtl/ddr2_pkg.sv
// Shared DDR2 write-path constants and the pad FSM state type.
package ddr2_pkg;

    localparam int unsigned DDR2_DATA_W    = 144;
    localparam int unsigned DDR2_BURST_LEN = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PAD
    } pad_state_t;

endpackage

// File: rtl/ddr2_sync_fifo.sv
// Show-ahead synchronous FIFO: RAM storage, wrapping pointers, separate occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module ddr2_sync_fifo #(
    parameter int unsigned DATA_W = 144,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned         PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage write; left unreset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/ddr2_wr_stager.sv
// Write-data staging buffer ahead of the DDR2 driver: requests a write only once a
// full burst is resident and pads a stranded partial burst on timeout or flush.
module ddr2_wr_stager
    import ddr2_pkg::*;
#(
    parameter int unsigned       DATA_W        = DDR2_DATA_W,
    parameter int unsigned       DEPTH         = 32,
    parameter int unsigned       BURST_LEN     = DDR2_BURST_LEN,
    parameter int unsigned       FLUSH_TIMEOUT = 64,
    parameter logic [DATA_W-1:0] PAD_WORD      = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    wr_req_from_tmto,
    output logic [DATA_W-1:0]       tmto_fifo_q,
    input  logic                    tmto_fifo_rdacked,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             pad_cnt,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned         CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]    BURST_CNT    = CNT_W'(BURST_LEN);
    localparam logic [15:0]         TIMEOUT_LAST = 16'(FLUSH_TIMEOUT - 1);

    pad_state_t        state;
    pad_state_t        state_nxt;
    logic [15:0]       idle_cnt;
    logic              full;
    logic              empty;
    logic              prod_push;
    logic              pad_push;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  count_nxt;
    logic              residual_nxt;

    assign in_ready         = !full && (state != PAD);
    assign prod_push        = in_valid && in_ready;
    assign pad_push         = (state == PAD) && !full;
    assign push             = prod_push || pad_push;
    assign pop              = tmto_fifo_rdacked && !empty;
    assign wdata            = pad_push ? PAD_WORD : in_data;
    assign wr_req_from_tmto = (count >= BURST_CNT);

    ddr2_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (tmto_fifo_q),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Residual is judged on the post-edge occupancy: this lets PAD stop on the very
    // edge that completes the burst, and starts the idle timer on the producer's push edge
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
        residual_nxt = (count_nxt % BURST_CNT) != '0;
    end

    // Pad FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pad FSM next-state: residual cleared wins over timeout/flush
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (residual_nxt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!residual_nxt) begin
                    state_nxt = IDLE;
                end else if (flush || (!prod_push && (idle_cnt == TIMEOUT_LAST))) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                if (!residual_nxt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Idle timer: counts push-free cycles while waiting, zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state == WAIT) && (state_nxt == WAIT) && !prod_push) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    // Sticky error flags and saturating pad counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            pad_cnt   <= '0;
        end else begin
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
            if (tmto_fifo_rdacked && empty) begin
                underflow <= 1'b1;
            end
            if (pad_push && (pad_cnt != '1)) begin
                pad_cnt <= pad_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_wr_stager.sv
// Self-checking bench for ddr2_wr_stager: vector table, directed corner sequences,
// and randomized push/pop traffic against a queue model.
module tb_ddr2_wr_stager;

    localparam int unsigned W     = 144;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned BL    = 2;
    localparam int unsigned FT    = 64;
    localparam logic [W-1:0] PADW = {9{16'hD00D}};

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          flush;
    logic          wr_req;
    logic [W-1:0]  q;
    logic          ack;
    logic [5:0]    count;
    logic [15:0]   pad_cnt;
    logic          overflow;
    logic          underflow;

    int unsigned n_pass;
    int unsigned n_total;

    ddr2_wr_stager #(
        .DATA_W        (W),
        .DEPTH         (DEPTH),
        .BURST_LEN     (BL),
        .FLUSH_TIMEOUT (FT),
        .PAD_WORD      (PADW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .flush             (flush),
        .wr_req_from_tmto  (wr_req),
        .tmto_fifo_q       (q),
        .tmto_fifo_rdacked (ack),
        .count             (count),
        .pad_cnt           (pad_cnt),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] data;
        logic         fl;
        logic         ack;
        int unsigned  e_count;
        logic         e_req;
        logic         e_ready;
        logic         chk_q;
        logic [W-1:0] e_q;
        int unsigned  e_pad;
    } vec_t;

    vec_t vt[$];

    function automatic logic [W-1:0] wd(input logic [15:0] tag);
        return {9{tag}};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [W-1:0] data, input logic fl,
                                input logic a, input int unsigned e_count, input logic e_req,
                                input logic e_ready, input logic chk_q, input logic [W-1:0] e_q,
                                input int unsigned e_pad);
        vec_t v;
        v.iv = iv; v.data = data; v.fl = fl; v.ack = a;
        v.e_count = e_count; v.e_req = e_req; v.e_ready = e_ready;
        v.chk_q = chk_q; v.e_q = e_q; v.e_pad = e_pad;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        ack      = 1'b0;
    endtask

    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_unf;
    int unsigned  since_push;
    logic [159:0] rnd;
    logic         r_iv;
    logic         r_ack;
    logic         m_full;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle_in();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_wr_req", W'(wr_req), W'(0));
        chk("rst_count", W'(count), W'(0));
        chk("rst_pad_cnt", W'(pad_cnt), W'(0));
        chk("rst_overflow", W'(overflow), W'(0));
        chk("rst_underflow", W'(underflow), W'(0));

        // Burst threshold, then flush of a 3-word residual, then drain
        vt.push_back(mk(1'b1, wd(16'hA000), 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, wd(16'hA000), 0));
        vt.push_back(mk(1'b1, wd(16'hA001), 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1, wd(16'hA000), 0));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, wd(16'hA001), 0));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, '0,           0));
        vt.push_back(mk(1'b1, wd(16'hC000), 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, wd(16'hC000), 0));
        vt.push_back(mk(1'b1, wd(16'hC001), 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1, wd(16'hC000), 0));
        vt.push_back(mk(1'b1, wd(16'hC002), 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, wd(16'hC000), 0));
        vt.push_back(mk(1'b0, '0,           1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, wd(16'hC000), 0));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, wd(16'hC000), 1));
        vt.push_back(mk(1'b0, '0,           1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b1, wd(16'hC000), 1));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, wd(16'hC000), 1));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, wd(16'hC001), 1));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b1, wd(16'hC002), 1));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, PADW,         1));
        vt.push_back(mk(1'b0, '0,           1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, '0,           1));

        for (int i = 0; i < vt.size(); i++) begin
            in_valid = vt[i].iv;
            in_data  = vt[i].data;
            flush    = vt[i].fl;
            ack      = vt[i].ack;
            step();
            chk($sformatf("vec%0d_count", i), W'(count), W'(vt[i].e_count));
            chk($sformatf("vec%0d_wr_req", i), W'(wr_req), W'(vt[i].e_req));
            chk($sformatf("vec%0d_in_ready", i), W'(in_ready), W'(vt[i].e_ready));
            chk($sformatf("vec%0d_pad_cnt", i), W'(pad_cnt), W'(vt[i].e_pad));
            if (vt[i].chk_q) begin
                chk($sformatf("vec%0d_q", i), q, vt[i].e_q);
            end
        end
        idle_in();

        // Timeout pad: single word, then idle; pad lands FT+1 edges after the push
        in_valid = 1'b1;
        in_data  = wd(16'hB000);
        step();
        idle_in();
        repeat (FT - 1) step();
        chk("tmo_ready_before", W'(in_ready), W'(1));
        chk("tmo_count_before", W'(count), W'(1));
        step();
        chk("tmo_ready_pad", W'(in_ready), W'(0));
        chk("tmo_count_pad_state", W'(count), W'(1));
        step();
        chk("tmo_count", W'(count), W'(2));
        chk("tmo_pad_cnt", W'(pad_cnt), W'(2));
        chk("tmo_wr_req", W'(wr_req), W'(1));
        chk("tmo_q0", q, wd(16'hB000));
        ack = 1'b1;
        step();
        chk("tmo_q1", q, PADW);
        step();
        ack = 1'b0;
        chk("tmo_drained", W'(count), W'(0));

        // Full: 32 pushes, overflow attempt, push+pop at 31, readback order
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = wd(16'h1000 + 16'(i));
            step();
        end
        chk("full_count", W'(count), W'(32));
        chk("full_in_ready", W'(in_ready), W'(0));
        chk("full_no_ovf_yet", W'(overflow), W'(0));
        in_data = wd(16'hEEEE);
        step();
        chk("full_overflow", W'(overflow), W'(1));
        chk("full_count_ovf", W'(count), W'(32));
        in_valid = 1'b0;
        ack      = 1'b1;
        step();
        chk("full_pop_count", W'(count), W'(31));
        chk("full_pop_q", q, wd(16'h1001));
        in_valid = 1'b1;
        in_data  = wd(16'h2000);
        step();
        chk("full_pp_count", W'(count), W'(31));
        chk("full_pp_q", q, wd(16'h1002));
        in_valid = 1'b0;
        for (int k = 2; k < 33; k++) begin
            chk($sformatf("full_rd%0d", k), q, (k < 32) ? wd(16'h1000 + 16'(k)) : wd(16'h2000));
            step();
        end
        ack = 1'b0;
        chk("full_drained", W'(count), W'(0));

        // Underflow
        chk("unf_before", W'(underflow), W'(0));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("unf_flag", W'(underflow), W'(1));
        chk("unf_count", W'(count), W'(0));

        // Reset mid-burst
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = wd(16'h3000 + 16'(i));
            step();
        end
        in_valid = 1'b0;
        chk("mid_count5", W'(count), W'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_in_ready", W'(in_ready), W'(1));
        chk("mid_wr_req", W'(wr_req), W'(0));
        chk("mid_count", W'(count), W'(0));
        chk("mid_pad_cnt", W'(pad_cnt), W'(0));
        chk("mid_overflow", W'(overflow), W'(0));
        chk("mid_underflow", W'(underflow), W'(0));
        in_valid = 1'b1;
        in_data  = wd(16'h5A5A);
        step();
        in_valid = 1'b0;
        chk("mid_push_q", q, wd(16'h5A5A));
        chk("mid_push_count", W'(count), W'(1));

        // Random push/pop traffic; producer pushes often enough that no pad is due
        mq.delete();
        mq.push_back(wd(16'h5A5A));
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        since_push = 0;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd_count", W'(count), W'(mq.size()));
            chk("rnd_wr_req", W'(wr_req), W'(mq.size() >= BL));
            chk("rnd_in_ready", W'(in_ready), W'(mq.size() < DEPTH));
            chk("rnd_overflow", W'(overflow), W'(m_ovf));
            chk("rnd_underflow", W'(underflow), W'(m_unf));
            chk("rnd_pad_cnt", W'(pad_cnt), W'(0));
            if (mq.size() != 0) begin
                chk("rnd_q", q, mq[0]);
            end
            r_iv  = ($urandom_range(0, 99) < 45) || (since_push >= 8);
            r_ack = ($urandom_range(0, 99) < 55);
            rnd   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = r_iv;
            in_data  = rnd[W-1:0];
            ack      = r_ack;
            m_full   = (mq.size() == DEPTH);
            if (r_iv && m_full) m_ovf = 1'b1;
            if (r_ack && mq.size() == 0) m_unf = 1'b1;
            if (r_ack && mq.size() != 0) void'(mq.pop_front());
            if (r_iv && !m_full) begin
                mq.push_back(rnd[W-1:0]);
                since_push = 0;
            end else begin
                since_push++;
            end
            step();
        end
        idle_in();
        chk("rnd_final_count", W'(count), W'(mq.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
